branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Execute-stage branch resolution and prediction-state block. Sits directly downstream of the ID/EX pipeline register and consumes its pc, operand, opcode, prediction and saved-PC fields. Decides each conditional branch, detects mispredictions, and issues a one-cycle flush plus a redirect PC to fetch and to the IF/ID and ID/EX registers. Owns the pattern history table (PHT) of 2-bit saturating predictor state machines, which fetch reads through a lookup port.

## Interface
- PC_WIDTH, 8: width of word-addressed PCs.
- DATA_WIDTH, 32: width of register operands.
- ALU_OPCODE_WIDTH, 4: width of alu_opcode_in.
- PHT_INDEX_WIDTH, 4: log2 of the PHT entry count; index = pc[PHT_INDEX_WIDTH-1:0].
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- pc_in  in  PC_WIDTH  PC of the instruction in EX (ID/EX pc_out).
- rd_data1_in  in  DATA_WIDTH  operand A.
- rd_data2_in  in  DATA_WIDTH  operand B.
- alu_opcode_in  in  ALU_OPCODE_WIDTH  opcode; 0 = NOP/bubble.
- prediction_in  in  1  direction predicted at fetch (1 = taken).
- save_pc_in  in  PC_WIDTH  PC of the path not taken by the prediction.
- lookup_pc_in  in  PC_WIDTH  fetch PC for prediction lookup.
- lookup_taken_out  out  1  combinational: MSB of PHT[lookup_pc_in index].
- flush_out  out  1  registered; flush IF/ID and ID/EX; fetch loads redirect_pc_out.
- redirect_pc_out  out  PC_WIDTH  registered correct-path PC, valid while flush_out = 1.
- branch_cnt_out  out  CNT_WIDTH  resolved branches, saturating.
- mispredict_cnt_out  out  CNT_WIDTH  mispredictions, saturating.

## Operation
- is_branch = (opcode == OP_BEQ or OP_BNE) and not flush_out. While flush_out = 1, EX holds a wrong-path instruction, so that cycle is squashed: no update, no count, and no flush.
- taken = BEQ: rd_data1_in == rd_data2_in; BNE: rd_data1_in != rd_data2_in. Full-width unsigned compare.
- mispredict = is_branch and (taken != prediction_in).
- Posedge with mispredict: flush_out <= 1, redirect_pc_out <= save_pc_in. Otherwise flush_out <= 0. redirect_pc_out holds its last value.
- PHT entry FSM, per entry: SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11).
  - Taken moves one state toward ST; saturates at ST.
  - Not taken moves one state toward SNT; saturates at SNT.
  - Only is_branch cycles update, and only entry pc_in[PHT_INDEX_WIDTH-1:0].
- Lookup reads the current registered PHT. A same-cycle update to the same index becomes visible the next cycle (no bypass).
- branch_cnt increments on every is_branch. mispredict_cnt increments on every mispredict. Both hold at all-ones.

## Timing
- Reset values: flush_out 0, redirect_pc_out 0, branch_cnt_out 0, mispredict_cnt_out 0, every PHT entry WNT (01). lookup_taken_out therefore reads 0 after reset.
- Reset asserted mid-flush clears flush_out on that edge. Reset overrides any simultaneous update.
- Resolution is combinational within the EX cycle (cycle t). flush_out and redirect_pc_out are valid in cycle t+1 only: exactly one cycle wide.
- PHT and counter updates land at the end of cycle t.
- Back-to-back branches: a branch in t+1 (flush shadow) is ignored. The next eligible branch is in t+2.
- A correctly predicted branch produces no flush; the PHT still trains.

## Structure
- Package branch_pkg holds:
  - opcode constants OP_NOP = 0, OP_BEQ = 4'hA, OP_BNE = 4'hB;
  - the PHT state encoding SNT/WNT/WT/ST;
  - the reset state PHT_RESET = WNT.
- One sub-module, pht_counter2: a single 2-bit saturating FSM with ports clk, reset, update_en, taken, state_out. It is instantiated 2**PHT_INDEX_WIDTH times via generate.

## Test plan
- Reset, then lookup_pc_in = 8'h05 -> lookup_taken_out = 0; all outputs 0.
- BEQ, pc_in = 8'h05, data 7/7, prediction 0, save_pc_in = 8'h20 -> next cycle flush_out = 1, redirect_pc_out = 8'h20; PHT[5] = WT; lookup 8'h05 -> 1; both counters = 1.
- BNE with data 3/3, prediction 0 -> no flush; branch_cnt increments, mispredict_cnt unchanged; PHT entry moves toward SNT.
- Mispredicting BEQ in cycle t, second mispredicting BEQ in t+1 -> single one-cycle flush; second branch not counted, PHT unchanged for it.
- Four taken BEQs on pc 8'h13 (index 3) -> entry saturates at ST. One not-taken -> WT, and the lookup still predicts taken.
- Reset asserted in the cycle flush_out = 1 -> flush_out 0 next cycle, counters 0, PHT back to WNT. Force branch_cnt to all-ones -> it stays all-ones on the next branch.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants for the execute-stage branch resolution block:
// opcode values and the 2-bit PHT predictor state encoding.
package branch_pkg;

  // Opcodes seen on alu_opcode_in
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_BEQ = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hB;

  // PHT predictor states; the MSB is the predicted direction
  localparam logic [1:0] PHT_SNT = 2'b00;
  localparam logic [1:0] PHT_WNT = 2'b01;
  localparam logic [1:0] PHT_WT  = 2'b10;
  localparam logic [1:0] PHT_ST  = 2'b11;

  // Every entry starts weakly not-taken
  localparam logic [1:0] PHT_RESET = PHT_WNT;

  // One-step saturating move toward ST (taken) or SNT (not taken)
  function automatic logic [1:0] pht_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != PHT_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != PHT_SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pht_counter2.sv
// Single 2-bit saturating direction predictor. The state register is
// exported directly on state_out so the predictor FSM is observable.
module pht_counter2
  import branch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       update_en,
  input  logic       taken,
  output logic [1:0] state_out
);

  logic [1:0] state;

  // Train one step per resolved branch; reset returns to weakly not-taken
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PHT_RESET;
    end else if (update_en) begin
      state <= pht_next(state, taken);
    end
  end

  assign state_out = state;

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: decides BEQ/BNE, detects
// mispredictions, issues a one-cycle flush with the correct-path PC,
// trains the PHT and keeps saturating branch/mispredict statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int PC_WIDTH         = 8,
  parameter int DATA_WIDTH       = 32,
  parameter int ALU_OPCODE_WIDTH = 4,
  parameter int PHT_INDEX_WIDTH  = 4,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PC_WIDTH-1:0]         pc_in,
  input  logic [DATA_WIDTH-1:0]       rd_data1_in,
  input  logic [DATA_WIDTH-1:0]       rd_data2_in,
  input  logic [ALU_OPCODE_WIDTH-1:0] alu_opcode_in,
  input  logic                        prediction_in,
  input  logic [PC_WIDTH-1:0]         save_pc_in,
  input  logic [PC_WIDTH-1:0]         lookup_pc_in,
  output logic                        lookup_taken_out,
  output logic                        flush_out,
  output logic [PC_WIDTH-1:0]         redirect_pc_out,
  output logic [CNT_WIDTH-1:0]        branch_cnt_out,
  output logic [CNT_WIDTH-1:0]        mispredict_cnt_out
);

  localparam int PHT_ENTRIES = 2 ** PHT_INDEX_WIDTH;

  logic                       is_beq;
  logic                       is_bne;
  logic                       is_branch;
  logic                       operands_equal;
  logic                       taken;
  logic                       mispredict;
  logic [PHT_INDEX_WIDTH-1:0] update_idx;
  logic [PHT_INDEX_WIDTH-1:0] lookup_idx;
  logic [1:0]                 pht_state [PHT_ENTRIES];

  // Resolve the branch in EX. The instruction sitting in EX while a
  // flush is out is wrong-path, so it is squashed entirely.
  always_comb begin
    is_beq         = (alu_opcode_in == ALU_OPCODE_WIDTH'(OP_BEQ));
    is_bne         = (alu_opcode_in == ALU_OPCODE_WIDTH'(OP_BNE));
    is_branch      = (is_beq || is_bne) && !flush_out;
    operands_equal = (rd_data1_in == rd_data2_in);
    taken          = is_beq ? operands_equal : !operands_equal;
    mispredict     = is_branch && (taken != prediction_in);
  end

  assign update_idx = pc_in[PHT_INDEX_WIDTH-1:0];
  assign lookup_idx = lookup_pc_in[PHT_INDEX_WIDTH-1:0];

  // One-cycle flush pulse; the redirect PC holds until the next mispredict
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_out       <= 1'b0;
      redirect_pc_out <= '0;
    end else begin
      flush_out <= mispredict;
      if (mispredict) begin
        redirect_pc_out <= save_pc_in;
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_out     <= '0;
      mispredict_cnt_out <= '0;
    end else begin
      if (is_branch && (branch_cnt_out != '1)) begin
        branch_cnt_out <= branch_cnt_out + 1'b1;
      end
      if (mispredict && (mispredict_cnt_out != '1)) begin
        mispredict_cnt_out <= mispredict_cnt_out + 1'b1;
      end
    end
  end

  // Pattern history table: one predictor per index, only the entry
  // addressed by the resolving branch trains
  for (genvar i = 0; i < PHT_ENTRIES; i++) begin : g_pht
    pht_counter2 u_cnt (
      .clk       (clk),
      .reset     (reset),
      .update_en (is_branch && (update_idx == PHT_INDEX_WIDTH'(i))),
      .taken     (taken),
      .state_out (pht_state[i])
    );
  end

  // Fetch sees registered state only; same-cycle training shows up next cycle
  assign lookup_taken_out = pht_state[lookup_idx][1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a vector table applied one
// per cycle, plus hand-written reset-during-flush and saturation sequences.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  pc_in;
  logic [31:0] rd_data1_in;
  logic [31:0] rd_data2_in;
  logic [3:0]  alu_opcode_in;
  logic        prediction_in;
  logic [7:0]  save_pc_in;
  logic [7:0]  lookup_pc_in;
  logic        lookup_taken_out;
  logic        flush_out;
  logic [7:0]  redirect_pc_out;
  logic [15:0] branch_cnt_out;
  logic [15:0] mispredict_cnt_out;

  int checks;
  int failures;

  branch_resolve_unit dut (
    .clk                (clk),
    .reset              (reset),
    .pc_in              (pc_in),
    .rd_data1_in        (rd_data1_in),
    .rd_data2_in        (rd_data2_in),
    .alu_opcode_in      (alu_opcode_in),
    .prediction_in      (prediction_in),
    .save_pc_in         (save_pc_in),
    .lookup_pc_in       (lookup_pc_in),
    .lookup_taken_out   (lookup_taken_out),
    .flush_out          (flush_out),
    .redirect_pc_out    (redirect_pc_out),
    .branch_cnt_out     (branch_cnt_out),
    .mispredict_cnt_out (mispredict_cnt_out)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  op;
    logic        pred;
    logic [7:0]  save;
    logic [7:0]  look;
    logic        e_flush;
    logic [7:0]  e_redir;
    logic [15:0] e_bcnt;
    logic [15:0] e_mcnt;
    logic        e_look;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [7:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [3:0] op, input logic pred, input logic [7:0] save,
                              input logic [7:0] look, input logic e_flush, input logic [7:0] e_redir,
                              input logic [15:0] e_bcnt, input logic [15:0] e_mcnt, input logic e_look);
    vec_t v;
    v.pc = pc; v.d1 = d1; v.d2 = d2; v.op = op; v.pred = pred; v.save = save; v.look = look;
    v.e_flush = e_flush; v.e_redir = e_redir; v.e_bcnt = e_bcnt; v.e_mcnt = e_mcnt; v.e_look = e_look;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one EX-stage instruction at the falling edge
  task automatic drive(input logic [7:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [3:0] op, input logic pred, input logic [7:0] save,
                       input logic [7:0] look);
    @(negedge clk);
    pc_in = pc; rd_data1_in = d1; rd_data2_in = d2; alu_opcode_in = op;
    prediction_in = pred; save_pc_in = save; lookup_pc_in = look;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    alu_opcode_in = OP_NOP;
    settle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    pc_in = '0; rd_data1_in = '0; rd_data2_in = '0; alu_opcode_in = OP_NOP;
    prediction_in = 1'b0; save_pc_in = '0; lookup_pc_in = 8'h05;

    //            pc     d1            d2            op      pr  save   look   fl  redir  bcnt   mcnt  look
    vecs[0]  = mk(8'h05, 32'd7,        32'd7,        OP_BEQ, 0, 8'h20, 8'h05, 1, 8'h20, 16'd1, 16'd1, 1);
    vecs[1]  = mk(8'h00, 32'd0,        32'd0,        OP_NOP, 0, 8'h00, 8'h05, 0, 8'h20, 16'd1, 16'd1, 1);
    vecs[2]  = mk(8'h05, 32'd3,        32'd3,        OP_BNE, 0, 8'h30, 8'h05, 0, 8'h20, 16'd2, 16'd1, 0);
    vecs[3]  = mk(8'h06, 32'd1,        32'd2,        OP_BEQ, 1, 8'h40, 8'h06, 1, 8'h40, 16'd3, 16'd2, 0);
    vecs[4]  = mk(8'h07, 32'd5,        32'd5,        OP_BEQ, 0, 8'h50, 8'h07, 0, 8'h40, 16'd3, 16'd2, 0);
    vecs[5]  = mk(8'h13, 32'd9,        32'd9,        OP_BEQ, 1, 8'h60, 8'h13, 0, 8'h40, 16'd4, 16'd2, 1);
    vecs[6]  = mk(8'h13, 32'd9,        32'd9,        OP_BEQ, 1, 8'h60, 8'h13, 0, 8'h40, 16'd5, 16'd2, 1);
    vecs[7]  = mk(8'h13, 32'd9,        32'd9,        OP_BEQ, 1, 8'h60, 8'h13, 0, 8'h40, 16'd6, 16'd2, 1);
    vecs[8]  = mk(8'h13, 32'd9,        32'd9,        OP_BEQ, 1, 8'h60, 8'h13, 0, 8'h40, 16'd7, 16'd2, 1);
    vecs[9]  = mk(8'h13, 32'd9,        32'd8,        OP_BEQ, 1, 8'h61, 8'h13, 1, 8'h61, 16'd8, 16'd3, 1);
    vecs[10] = mk(8'h00, 32'd0,        32'd0,        OP_NOP, 0, 8'h00, 8'h13, 0, 8'h61, 16'd8, 16'd3, 1);
    vecs[11] = mk(8'h2A, 32'd1,        32'd2,        OP_BNE, 0, 8'h70, 8'h2A, 1, 8'h70, 16'd9, 16'd4, 1);
    vecs[12] = mk(8'h00, 32'd0,        32'd0,        OP_NOP, 0, 8'h00, 8'h25, 0, 8'h70, 16'd9, 16'd4, 0);
    vecs[13] = mk(8'h13, 32'd0,        32'd1,        OP_BEQ, 0, 8'h80, 8'h13, 0, 8'h70, 16'd10, 16'd4, 0);
    vecs[14] = mk(8'h08, 32'h80000001, 32'h00000001, OP_BEQ, 1, 8'h90, 8'h18, 1, 8'h90, 16'd11, 16'd5, 0);
    vecs[15] = mk(8'h00, 32'd0,        32'd0,        OP_NOP, 0, 8'h00, 8'h13, 0, 8'h90, 16'd11, 16'd5, 0);

    // Reset state
    settle();
    settle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_lookup", 32'(lookup_taken_out), 32'd0);
    check("reset_flush", 32'(flush_out), 32'd0);
    check("reset_redirect", 32'(redirect_pc_out), 32'h0);
    check("reset_bcnt", 32'(branch_cnt_out), 32'd0);
    check("reset_mcnt", 32'(mispredict_cnt_out), 32'd0);

    // Vector table, one instruction per cycle
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].pc, vecs[i].d1, vecs[i].d2, vecs[i].op, vecs[i].pred, vecs[i].save, vecs[i].look);
      settle();
      check($sformatf("v%0d_flush", i), 32'(flush_out), 32'(vecs[i].e_flush));
      check($sformatf("v%0d_redirect", i), 32'(redirect_pc_out), 32'(vecs[i].e_redir));
      check($sformatf("v%0d_bcnt", i), 32'(branch_cnt_out), 32'(vecs[i].e_bcnt));
      check($sformatf("v%0d_mcnt", i), 32'(mispredict_cnt_out), 32'(vecs[i].e_mcnt));
      check($sformatf("v%0d_lookup", i), 32'(lookup_taken_out), 32'(vecs[i].e_look));
    end

    // Reset asserted while flush is out, with a mispredicting branch on the inputs
    drive(8'h13, 32'd4, 32'd4, OP_BEQ, 0, 8'hA0, 8'h13);
    settle();
    check("pre_reset_flush", 32'(flush_out), 32'd1);
    check("pre_reset_lookup", 32'(lookup_taken_out), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    settle();
    check("rst_mid_flush", 32'(flush_out), 32'd0);
    check("rst_mid_redirect", 32'(redirect_pc_out), 32'h0);
    check("rst_mid_bcnt", 32'(branch_cnt_out), 32'd0);
    check("rst_mid_mcnt", 32'(mispredict_cnt_out), 32'd0);
    check("rst_mid_lookup13", 32'(lookup_taken_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    alu_opcode_in = OP_NOP;
    lookup_pc_in = 8'h2A;
    #1;
    check("rst_mid_lookup2a", 32'(lookup_taken_out), 32'd0);

    // Counter saturation: correctly predicted branches back to back
    drive(8'h01, 32'd2, 32'd2, OP_BEQ, 1, 8'h00, 8'h01);
    repeat (65535) @(posedge clk);
    #1;
    check("sat_bcnt_reach", 32'(branch_cnt_out), 32'hFFFF);
    check("sat_mcnt_zero", 32'(mispredict_cnt_out), 32'd0);
    settle();
    check("sat_bcnt_hold", 32'(branch_cnt_out), 32'hFFFF);
    check("sat_no_flush", 32'(flush_out), 32'd0);
    check("sat_lookup", 32'(lookup_taken_out), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
